// File: rtl/alu_csa_pkg.sv
// rtl/alu_csa_pkg.sv - shared state encoding and defaults for the CSA accumulator path
package alu_csa_pkg;

  typedef enum logic [2:0] {
    S_FLUSH   = 3'd0,
    S_ACCEPT  = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_RESOLVE = 3'd4,
    S_OUT     = 3'd5
  } csa_state_e;

  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 8;
  localparam int FLUSH_DEF   = 2;
  localparam int CSA_LAT     = 2;

endpackage

// File: rtl/csa_resolve_add.sv
// rtl/csa_resolve_add.sv - registered carry-propagate resolve of sum + (carry << 1) with carry-out
module csa_resolve_add #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] sum_in,
  input  logic [W-2:0] carry_in,
  output logic [W-1:0] res,
  output logic         cout
);

  logic [W-1:0] res_q, res_d;
  logic         cout_q, cout_d;

  always_comb begin
    res_d  = res_q;
    cout_d = cout_q;
    if (en) begin
      {cout_d, res_d} = {1'b0, sum_in} + {1'b0, carry_in, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      cout_q <= cout_d;
    end
  end

  assign res  = res_q;
  assign cout = cout_q;

endmodule

// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - operand accumulator sequencing a shared 3:2 CSA slice
// Optional sticky overflow output res_ovf under macro CSA_ACC_OVF_EN.
module csa_accum_ctrl
  import alu_csa_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int FLUSH   = FLUSH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_data,
  input  logic         op_last,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
`ifdef CSA_ACC_OVF_EN
  output logic         res_ovf,
`endif
  output logic         err,
  output logic         csa_v,
  output logic [W-1:0] csa_a,
  output logic [W-1:0] csa_b,
  output logic [W-1:0] csa_cin,
  input  logic [W-1:0] csa_sum,
  input  logic [W-1:0] csa_carry,
  input  logic         csa_v_out
);

  localparam int CW = $clog2(TIMEOUT + FLUSH + CSA_LAT + 1);

  csa_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] acc_sum_q, acc_sum_d;
  logic [W-2:0] acc_carry_q, acc_carry_d;
  logic         last_q, last_d;
  logic         err_q, err_d;
  logic [W-1:0] csa_a_q, csa_a_d;
  logic [W-1:0] csa_b_q, csa_b_d;
  logic [W-1:0] csa_cin_q, csa_cin_d;
  logic         rs_en;
  logic         rs_cout;
`ifdef CSA_ACC_OVF_EN
  logic         ovf_q, ovf_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_sum_d   = acc_sum_q;
    acc_carry_d = acc_carry_q;
    last_d      = last_q;
    err_d       = 1'b0;
    csa_a_d     = csa_a_q;
    csa_b_d     = csa_b_q;
    csa_cin_d   = csa_cin_q;
    rs_en       = 1'b0;
`ifdef CSA_ACC_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_FLUSH: begin
        if (cnt_q == CW'(FLUSH - 1)) begin
          state_d = S_ACCEPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACCEPT: begin
        if (op_valid) begin
          csa_a_d   = op_data;
          csa_b_d   = acc_sum_q;
          csa_cin_d = {acc_carry_q, 1'b0};
          last_d    = op_last;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (csa_v_out) begin
          acc_sum_d   = csa_sum;
          acc_carry_d = csa_carry[W-2:0];
`ifdef CSA_ACC_OVF_EN
          ovf_d       = ovf_q | csa_carry[W-1];
`endif
          state_d     = last_q ? S_RESOLVE : S_ACCEPT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abort drops the whole accumulation; FLUSH drains any late slice response.
          err_d       = 1'b1;
          acc_sum_d   = '0;
          acc_carry_d = '0;
          last_d      = 1'b0;
`ifdef CSA_ACC_OVF_EN
          ovf_d       = 1'b0;
`endif
          cnt_d       = '0;
          state_d     = S_FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESOLVE: begin
        rs_en   = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          acc_sum_d   = '0;
          acc_carry_d = '0;
          last_d      = 1'b0;
`ifdef CSA_ACC_OVF_EN
          ovf_d       = 1'b0;
`endif
          state_d     = S_ACCEPT;
        end
      end
      default: begin
        state_d = S_FLUSH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FLUSH;
      cnt_q       <= '0;
      acc_sum_q   <= '0;
      acc_carry_q <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      csa_a_q     <= '0;
      csa_b_q     <= '0;
      csa_cin_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_sum_q   <= acc_sum_d;
      acc_carry_q <= acc_carry_d;
      last_q      <= last_d;
      err_q       <= err_d;
      csa_a_q     <= csa_a_d;
      csa_b_q     <= csa_b_d;
      csa_cin_q   <= csa_cin_d;
    end
  end

  csa_resolve_add #(.W(W)) u_resolve (
    .clk      (clk),
    .rst      (rst),
    .en       (rs_en),
    .sum_in   (acc_sum_q),
    .carry_in (acc_carry_q),
    .res      (res_data),
    .cout     (rs_cout)
  );

`ifdef CSA_ACC_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // Resolve carry-out is only meaningful for the result currently presented.
  assign res_ovf = (state_q == S_OUT) & (ovf_q | rs_cout);
`else
  logic [1:0] unused_ovf_src;
  assign unused_ovf_src = {csa_carry[W-1], rs_cout};
`endif

  assign op_ready  = (state_q == S_ACCEPT);
  assign res_valid = (state_q == S_OUT);
  assign csa_v     = (state_q == S_ISSUE);
  assign err       = err_q;
  assign csa_a     = csa_a_q;
  assign csa_b     = csa_b_q;
  assign csa_cin   = csa_cin_q;

endmodule

// File: doc/csa_accum_ctrl.md
Name: csa_accum_ctrl

Overview:
Sequencer that accumulates a stream of W-bit operands through one shared 3:2 carry-save slice (`carry_slice4_csa`, 2-cycle registered latency).
- Each accepted operand is issued with the running sum and shifted carry vectors.
- The block waits for the slice response, then folds the returned vectors back into its accumulator.
- On the last operand it does one carry-propagate resolve and presents the sum, modulo 2^W.
- It sits between an operand producer (valid/ready) and a result consumer (valid/ready) in the ALU arithmetic path.

Parameters:
- W, 8, operand/slice width; must match the slice instance.
- TIMEOUT, 8, cycles allowed from issue to `csa_v_out` before aborting.
- FLUSH, 2, cycles `op_ready` is held low after reset or abort, to drain the slice pipeline.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operand valid
- op_ready  out  1  controller can accept an operand
- op_data  in  W  operand
- op_last  in  1  final operand of current accumulation
- res_valid  out  1  result valid, held until accepted
- res_ready  in  1  consumer accepts result
- res_data  out  W  accumulated sum mod 2^W
- err  out  1  one-cycle pulse on slice timeout
- csa_v  out  1  issue strobe to slice `v_in`
- csa_a  out  W  to slice `a_in`
- csa_b  out  W  to slice `b_in`
- csa_cin  out  W  to slice `cin_in`
- csa_sum  in  W  slice `sum`
- csa_carry  in  W  slice `carry` (unshifted)
- csa_v_out  in  1  slice `v_out`

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- States: FLUSH, ACCEPT, ISSUE, WAIT, RESOLVE, OUT.
- Reset:
  - state=FLUSH; acc_sum=0, acc_carry=0, last_r=0.
  - All outputs 0: `op_ready`, `res_valid`, `res_data`, `err`, `csa_v`, `csa_a`, `csa_b`, `csa_cin`.
- FLUSH: hold FLUSH cycles, then go to ACCEPT. `csa_v_out` is ignored.
- ACCEPT:
  - `op_ready`=1.
  - On `op_valid`&&`op_ready` at cycle t: capture `op_data` and `op_last`; go to ISSUE.
- ISSUE (cycle t+1):
  - `csa_v`=1, `csa_a`=operand, `csa_b`=acc_sum, `csa_cin`={acc_carry[W-2:0],1'b0}.
  - Exactly one cycle. Go to WAIT and clear the timeout counter.
  - `csa_a`/`csa_b`/`csa_cin` are registered and hold their value outside ISSUE; `csa_v`=0 outside ISSUE.
- WAIT:
  - Nominal response: `csa_v_out`=1 at t+3. Then acc_sum<=`csa_sum`, acc_carry<=`csa_carry`.
  - Next state after the response: RESOLVE if last_r, else ACCEPT. Throughput is 1 operand per 4 cycles.
- Timeout:
  - If TIMEOUT cycles elapse in WAIT without `csa_v_out`: `err`=1 for one cycle.
  - Clear the accumulator, drop the pending accumulation, go to FLUSH.
- RESOLVE (1 cycle): `res_data`<=acc_sum + {acc_carry[W-2:0],1'b0} (mod 2^W); go to OUT.
- OUT:
  - `res_valid`=1; `res_data` stable while `res_ready`=0.
  - On `res_ready`: `res_valid`<=0, accumulator cleared, go to ACCEPT.
- `csa_v_out` outside WAIT is ignored and never modifies state.
- `op_ready`=0 in every state except ACCEPT; the producer must hold `op_valid`/`op_data`/`op_last` stable.
- A single operand with `op_last`=1 produces that operand as the result.
- Reset in any state, including WAIT or OUT, discards all work; the FLUSH window absorbs the in-flight slice response.

Optional Feature:
- Macro: CSA_ACC_OVF_EN.
- When defined:
  - Adds output port `res_ovf` (1 bit).
  - A sticky overflow bit is set whenever a returned `csa_carry[W-1]`=1 (lost by the shift) or the RESOLVE adder carry-out=1.
  - `res_ovf` is valid with `res_valid` and is cleared with the accumulator and on reset.
- When undefined: no port, no overflow logic; results silently wrap mod 2^W.

Decomposition:
- Shared package `alu_csa_pkg`:
  - state encoding constants (FLUSH..OUT, 3-bit);
  - default W, TIMEOUT, FLUSH;
  - slice latency constant CSA_LAT=2.
- One natural sub-module, `csa_resolve_add`: registered W-bit carry-propagate resolve (sum + carry<<1) with carry-out, reused by other CSA consumers.
- FSM, accumulator and timeout counter stay in the top module.

Test Plan:
- Ops 3, 5, 7 (last) with a real `carry_slice4_csa` instance:
  - Expect `res_data`=15.
  - Expect each `csa_v` exactly 1 cycle.
  - Expect `op_ready` low for 3 cycles after each handshake.
- Ops 200, 100 (last): expect `res_data`=44; with CSA_ACC_OVF_EN expect `res_ovf`=1. Ops 10, 20 give `res_ovf`=0.
- Single op 0xAA (last) -> `res_data`=0xAA. Then hold `res_ready`=0 for 5 cycles: `res_valid`=1 and `res_data` stable throughout; `op_ready`=0 until accepted.
- Slice stub never asserts `csa_v_out`:
  - Expect `err` pulse exactly TIMEOUT cycles after the WAIT entry.
  - Then FLUSH, then `op_ready`=1.
  - Next accumulation 1, 2 (last) -> 3.
- Assert `rst` one cycle during WAIT of op 9:
  - Expect all outputs 0.
  - The stale `csa_v_out` 2 cycles later is ignored.
  - The following ops 4, 4 (last) -> 8.
- Spurious `csa_v_out` pulses during ACCEPT and OUT -> accumulator and `res_data` unchanged.
